window_extremum: RTL and testbench

- Parametrised successor to the fixed 100-sample running-maximum tracker.
- Scans a programmable-length window of qualified input samples and reports the running maximum or minimum, together with the window index at which it occurred.
- Supports signed or unsigned compare and a start/busy/done handshake, so a sequencer can rearm it without a reset.
- Sits between a sample source and a host/control register bank.

---
 rtl/window_extremum.sv | 141 ++++++++++++++
 tb/tb_window_extremum.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/window_extremum.sv
// rtl/window_extremum.sv - programmable-window running max/min tracker
//
// Purpose:
//   Scans a window of len qualified samples and reports the running maximum
//   (mode=0) or minimum (mode=1) together with the 0-based window index at
//   which it occurred. A start pulse rearms the block at any time.
//
// Ports:
//   clk   in   1       system clock, rising edge
//   rst   in   1       asynchronous active-low reset
//   start in   1       one-cycle pulse; latches len/mode, arms a new window
//   len   in   CNT_W   window length in samples (sampled on start)
//   mode  in   1       0 = track maximum, 1 = track minimum (sampled on start)
//   en    in   1       sample qualifier; x consumed when en=1 and busy=1
//   x     in   DATA_W  sample data
//   busy  out  1       window armed and accepting samples
//   done  out  1       one-cycle pulse when the window completes
//   y     out  DATA_W  current/final extremum
//   idx   out  CNT_W   window index of the sample held in y
//   cnt   out  CNT_W   samples accepted in the current window

module window_extremum #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              mode,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic [CNT_W-1:0]  idx,
  output logic [CNT_W-1:0]  cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_len;
  logic                r_mode;
  logic [DATA_W-1:0]   r_y;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;

  logic                w_arm;
  logic                w_accept;
  logic                w_done_nxt;
  logic                w_gt;
  logic                w_lt;
  logic                w_repl;
  logic [CNT_W-1:0]    w_cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start always wins over en, both in IDLE and when aborting a running window.
  // Completion is detected as cnt+1==len; cnt never exceeds len, so the
  // increment cannot wrap even for the largest window.
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_inc   = r_cnt + CNT_W'(1);
    if (start) begin
      w_arm = 1'b1;
      if (len != '0) begin
        w_state_nxt = RUN;
      end else begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
    end else if (r_state == RUN && en) begin
      w_accept = 1'b1;
      if (w_cnt_inc == r_len) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Strict compares keep the earliest occurrence on ties.
  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    if (SIGNED != 0) begin
      w_gt = $signed(x) > $signed(r_y);
      w_lt = $signed(x) < $signed(r_y);
    end else begin
      w_gt = x > r_y;
      w_lt = x < r_y;
    end
    w_repl = (r_cnt == '0) || (r_mode ? w_lt : w_gt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len  <= '0;
      r_mode <= 1'b0;
      r_y    <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_arm) begin
        r_len  <= len;
        r_mode <= mode;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
        if (w_repl) begin
          r_y   <= x;
          r_idx <= r_cnt;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign y    = r_y;
  assign idx  = r_idx;
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_window_extremum.sv
// tb/tb_window_extremum.sv - scoreboard bench for window_extremum

module tb_window_extremum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        mode;
  logic        en;
  logic [31:0] x;

  logic        busy0, done0, busy1, done1;
  logic [31:0] y0, y1;
  logic [15:0] idx0, idx1, cnt0, cnt1;

  typedef struct {
    logic [31:0] y;
    logic [15:0] idx;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done0 = 0;
  int n_done1 = 0;

  window_extremum #(.DATA_W(32), .CNT_W(16), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .en(en), .x(x),
    .busy(busy0), .done(done0), .y(y0), .idx(idx0), .cnt(cnt0)
  );

  window_extremum #(.DATA_W(32), .CNT_W(16), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .en(en), .x(x),
    .busy(busy1), .done(done1), .y(y1), .idx(idx1), .cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] yu, input logic [15:0] iu,
                      input logic [31:0] ys, input logic [15:0] is, input logic [15:0] c);
    exp_t e;
    e.y = yu; e.idx = iu; e.cnt = c; q0.push_back(e);
    e.y = ys; e.idx = is; e.cnt = c; q1.push_back(e);
  endtask

  task automatic step(input logic st, input logic [15:0] l, input logic m,
                      input logic e, input logic [31:0] d);
    @(negedge clk);
    start = st; len = l; mode = m; en = e; x = d;
  endtask

  task automatic quiet();
    step(1'b0, 16'd0, 1'b0, 1'b0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && done0) begin
      n_done0++;
      if (q0.size() == 0) begin
        check("u_extra_done", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("u_y", y0, e.y);
        check("u_idx", idx0, e.idx);
        check("u_cnt", cnt0, e.cnt);
        check("u_busy_at_done", busy0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done1) begin
      n_done1++;
      if (q1.size() == 0) begin
        check("s_extra_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("s_y", y1, e.y);
        check("s_idx", idx1, e.idx);
        check("s_cnt", cnt1, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; mode = 1'b0; en = 1'b0; x = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_y", y0, 0);
    check("rst_idx", idx0, 0);
    check("rst_cnt", cnt0, 0);
    rst = 1'b1;
    quiet();

    // unsigned max, tie keeps earliest index
    push(32'd9, 16'd1, 32'd9, 16'd1, 16'd4);
    step(1, 16'd4, 0, 0, 0);
    step(0, 0, 0, 1, 32'd5);
    check("t1_busy", busy0, 1);
    step(0, 0, 0, 1, 32'd9);
    step(0, 0, 0, 1, 32'd9);
    step(0, 0, 0, 1, 32'd3);
    check("t1_busy_before_end", busy0, 1);
    quiet();
    check("t1_done", done0, 1);
    check("t1_busy_fall", busy0, 0);
    quiet();
    check("t1_done_once", done0, 0);
    check("t1_cnt_hold", cnt0, 4);

    // min: signed vs unsigned interpretation
    push(32'h2, 16'd0, 32'h8000_0000, 16'd2, 16'd3);
    step(1, 16'd3, 1, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0002);
    step(0, 0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 1, 32'h8000_0000);
    quiet();
    check("t2_done_s", done1, 1);

    // en gaps; start with en=1 in IDLE drops that sample
    push(32'd8, 16'd2, 32'd8, 16'd2, 16'd3);
    step(1, 16'd3, 0, 1, 32'd50);
    step(0, 0, 0, 1, 32'd7);
    check("t3_cnt_first", cnt0, 0);
    step(0, 0, 0, 0, 32'd60);
    check("t3_y_first", y0, 7);
    step(0, 0, 0, 0, 32'd61);
    step(0, 0, 0, 1, 32'd1);
    step(0, 0, 0, 0, 32'd62);
    check("t3_cnt_gap", cnt0, 2);
    step(0, 0, 0, 1, 32'd8);
    check("t3_no_early_done", done0, 0);
    quiet();
    check("t3_done", done0, 1);

    // restart mid-window, en in start cycle dropped
    push(32'd40, 16'd0, 32'd40, 16'd0, 16'd2);
    step(1, 16'd5, 0, 0, 0);
    step(0, 0, 0, 1, 32'd100);
    step(0, 0, 0, 1, 32'd50);
    step(1, 16'd2, 1, 1, 32'd1);
    step(0, 0, 0, 1, 32'd40);
    check("t4_rearm_cnt", cnt0, 0);
    check("t4_busy", busy0, 1);
    step(0, 0, 0, 1, 32'd60);
    quiet();
    check("t4_done", done0, 1);

    // en in IDLE ignored
    step(0, 0, 0, 1, 32'd5);
    quiet();
    check("t5_idle_en_cnt", cnt0, 2);
    check("t5_idle_en_y", y0, 40);

    // len=0 start: immediate done, y/idx hold, cnt cleared
    push(32'd40, 16'd0, 32'd40, 16'd0, 16'd0);
    step(1, 16'd0, 0, 0, 0);
    quiet();
    check("t6_done", done0, 1);
    check("t6_busy", busy0, 0);

    // asynchronous reset mid-window
    step(1, 16'd4, 0, 0, 0);
    step(0, 0, 0, 1, 32'd11);
    step(0, 0, 0, 1, 32'd12);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t7_busy", busy0, 0);
    check("t7_y", y0, 0);
    check("t7_idx", idx0, 0);
    check("t7_cnt", cnt0, 0);
    check("t7_done", done0, 0);
    @(negedge clk);
    start = 1'b0; en = 1'b0;
    rst = 1'b1;
    push(32'hDEAD_BEEF, 16'd0, 32'hDEAD_BEEF, 16'd0, 16'd1);
    step(1, 16'd1, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    quiet();
    check("t7_done_after", done0, 1);
    quiet();
    quiet();

    check("q_u_empty", q0.size(), 0);
    check("q_s_empty", q1.size(), 0);
    check("n_done_u", n_done0, 6);
    check("n_done_s", n_done1, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
